// File: rtl/mem_loader.sv
// mem_loader: boot-time bus initiator for the hmc-6502 memory system.
// Receives a framed byte stream (addr, len, payload, checksum), writes the
// payload into memory, reads it back to verify, then releases the CPU.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset, waiting for start; bus left to the CPU
// H_ALO  | waiting for start-address low byte
// H_AHI  | waiting for start-address high byte
// H_LLO  | waiting for payload-length low byte
// H_LHI  | waiting for payload-length high byte
// RECV   | waiting for next payload byte
// WRITE  | one-cycle memory write of the latched byte
// CHK    | waiting for checksum byte
// V_ADDR | presenting read address for verify
// V_DATA | accumulating read-back byte
// DONE   | load verified; CPU released
// FAIL   | checksum or verify error; CPU held in reset
module mem_loader (
    input  logic        ph1,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [15:0] address,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in,
    output logic        read_en,
    output logic        bus_own,
    output logic        cpu_reset,
    output logic        done,
    output logic [1:0]  error
);

    typedef enum logic [3:0] {
        S_IDLE, S_H_ALO, S_H_AHI, S_H_LLO, S_H_LHI, S_RECV, S_WRITE,
        S_CHK, S_V_ADDR, S_V_DATA, S_DONE, S_FAIL
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ptr;
    logic [15:0] r_len;
    logic [15:0] r_hdr_ptr;
    logic [15:0] r_hdr_len;
    logic [7:0]  r_byte;
    logic [7:0]  r_fsum;
    logic [7:0]  r_wsum;
    logic [7:0]  r_rsum;
    logic [1:0]  r_error;

    logic        w_accept;
    logic        w_session_start;
    logic [7:0]  w_fsum_next;
    logic [7:0]  w_rsum_next;
    logic        w_last;

    assign w_accept        = in_valid & in_ready;
    assign w_session_start = start & ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                      (r_state == S_FAIL));
    assign w_fsum_next     = r_fsum + in_data;
    assign w_rsum_next     = r_rsum + data_in;
    // len is decremented on the same edge that leaves WRITE/V_DATA, so the
    // final byte is the one seen while len still reads 1.
    assign w_last          = (r_len == 16'd1);

    // The bus address simply follows the pointer; it is held through V_DATA
    // so a memory with either combinational or registered read sees it.
    assign address  = r_ptr;
    assign data_out = r_byte;
    assign error    = r_error;

    // State register.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and output decode; outputs depend on state only.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        bus_own   = 1'b1;
        cpu_reset = 1'b1;
        done      = 1'b0;
        data_oe   = 1'b0;
        read_en   = 1'b1;
        case (r_state)
            S_IDLE: begin
                bus_own = 1'b0;
                if (start) w_next = S_H_ALO;
            end
            S_H_ALO: begin
                in_ready = 1'b1;
                if (w_accept) w_next = S_H_AHI;
            end
            S_H_AHI: begin
                in_ready = 1'b1;
                if (w_accept) w_next = S_H_LLO;
            end
            S_H_LLO: begin
                in_ready = 1'b1;
                if (w_accept) w_next = S_H_LHI;
            end
            S_H_LHI: begin
                in_ready = 1'b1;
                if (w_accept)
                    w_next = ({in_data, r_len[7:0]} != 16'd0) ? S_RECV : S_CHK;
            end
            S_RECV: begin
                in_ready = 1'b1;
                if (w_accept) w_next = S_WRITE;
            end
            S_WRITE: begin
                data_oe = 1'b1;
                read_en = 1'b0;
                w_next  = w_last ? S_CHK : S_RECV;
            end
            S_CHK: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    if (w_fsum_next != 8'h00)      w_next = S_FAIL;
                    else if (r_hdr_len == 16'd0)   w_next = S_DONE;
                    else                           w_next = S_V_ADDR;
                end
            end
            S_V_ADDR: w_next = S_V_DATA;
            S_V_DATA: begin
                if (!w_last)                    w_next = S_V_ADDR;
                else if (w_rsum_next == r_wsum) w_next = S_DONE;
                else                            w_next = S_FAIL;
            end
            S_DONE: begin
                bus_own   = 1'b0;
                cpu_reset = 1'b0;
                done      = 1'b1;
                if (start) w_next = S_H_ALO;
            end
            S_FAIL: begin
                bus_own = 1'b0;
                if (start) w_next = S_H_ALO;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: header capture, pointer/length stepping, sums and error code.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            r_ptr     <= 16'h0000;
            r_len     <= 16'h0000;
            r_hdr_ptr <= 16'h0000;
            r_hdr_len <= 16'h0000;
            r_byte    <= 8'h00;
            r_fsum    <= 8'h00;
            r_wsum    <= 8'h00;
            r_rsum    <= 8'h00;
            r_error   <= 2'b00;
        end else if (w_session_start) begin
            r_fsum  <= 8'h00;
            r_wsum  <= 8'h00;
            r_rsum  <= 8'h00;
            r_error <= 2'b00;
        end else begin
            if (w_accept) r_fsum <= w_fsum_next;
            case (r_state)
                S_H_ALO: if (w_accept) r_ptr[7:0]  <= in_data;
                S_H_AHI: if (w_accept) r_ptr[15:8] <= in_data;
                S_H_LLO: if (w_accept) r_len[7:0]  <= in_data;
                S_H_LHI: if (w_accept) begin
                    r_len[15:8] <= in_data;
                    r_hdr_ptr   <= r_ptr;
                    r_hdr_len   <= {in_data, r_len[7:0]};
                end
                S_RECV: if (w_accept) begin
                    r_byte <= in_data;
                    r_wsum <= r_wsum + in_data;
                end
                S_WRITE: begin
                    r_ptr <= r_ptr + 16'd1;
                    r_len <= r_len - 16'd1;
                end
                S_CHK: if (w_accept) begin
                    if (w_fsum_next == 8'h00) begin
                        r_ptr  <= r_hdr_ptr;
                        r_len  <= r_hdr_len;
                        r_rsum <= 8'h00;
                    end else begin
                        r_error <= 2'b01;
                    end
                end
                S_V_DATA: begin
                    r_rsum <= w_rsum_next;
                    r_ptr  <= r_ptr + 16'd1;
                    r_len  <= r_len - 16'd1;
                    if (w_last && (w_rsum_next != r_wsum)) r_error <= 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a behavioural 64 KiB memory.
module tb_mem_loader;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [15:0] address;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  data_in;
    logic        read_en;
    logic        bus_own;
    logic        cpu_reset;
    logic        done;
    logic [1:0]  error;

    logic [7:0]  mem [0:65535];
    logic        force_bad = 1'b0;
    int          wr_cnt = 0;
    int          wr_base;
    int          n_pass = 0;
    int          n_chk = 0;
    logic [7:0]  frame [$];

    mem_loader dut (
        .ph1(ph1), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .address(address),
        .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
        .read_en(read_en), .bus_own(bus_own), .cpu_reset(cpu_reset),
        .done(done), .error(error)
    );

    always #5 ph1 = ~ph1;

    // Memory writes whenever read_en is low; registered read with optional
    // fault at 0x0201.
    always @(posedge ph1) begin
        if (!read_en) begin
            mem[address] <= data_out;
            wr_cnt       <= wr_cnt + 1;
        end
        data_in <= (force_bad && address == 16'h0201) ? 8'h00 : mem[address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge ph1);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int k;
        repeat (gap) @(negedge ph1);
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge ph1);
            k++;
        end
        if (k >= 50) chk("send_timeout", 0, 1);
        @(negedge ph1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap_max);
        foreach (frame[i]) send(frame[i], (gap_max == 0) ? 0 : $urandom_range(gap_max, 0));
    endtask

    task automatic wait_end(input string tag);
        int k = 0;
        while (!(done || error != 2'b00) && k < 200) begin
            @(negedge ph1);
            k++;
        end
        chk(tag, (k < 200) ? 1 : 0, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"}, address, 16'h0000);
        chk({tag, "_dout"}, data_out, 8'h00);
        chk({tag, "_oe"}, data_oe, 1'b0);
        chk({tag, "_rd"}, read_en, 1'b1);
        chk({tag, "_own"}, bus_own, 1'b0);
        chk({tag, "_cpurst"}, cpu_reset, 1'b1);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, error, 2'b00);
        chk({tag, "_rdy"}, in_ready, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge ph1);
        chk_reset_outputs("por");
        reset = 1'b0;
        @(negedge ph1);

        // T1: 3 bytes at 0x0200; frame sum before CHK is 0x34, so CHK = 0xCC.
        wr_base = wr_cnt;
        frame = '{8'h00, 8'h02, 8'h03, 8'h00, 8'hA9, 8'h01, 8'h85, 8'hCC};
        pulse_start();
        chk("t1_own", bus_own, 1'b1);
        send_frame(0);
        repeat (5) @(negedge ph1);
        chk("t1_cpurst_before", cpu_reset, 1'b1);
        @(negedge ph1);
        chk("t1_cpurst_17", cpu_reset, 1'b0);
        chk("t1_done", done, 1'b1);
        chk("t1_err", error, 2'b00);
        chk("t1_own_rel", bus_own, 1'b0);
        chk("t1_m200", mem[16'h0200], 8'hA9);
        chk("t1_m201", mem[16'h0201], 8'h01);
        chk("t1_m202", mem[16'h0202], 8'h85);
        chk("t1_writes", wr_cnt - wr_base, 3);

        // T2: same frame, checksum off by one.
        frame[7] = 8'hCD;
        pulse_start();
        chk("t2_done_clr", done, 1'b0);
        chk("t2_cpurst_re", cpu_reset, 1'b1);
        send_frame(0);
        wait_end("t2_tmo");
        chk("t2_err", error, 2'b01);
        chk("t2_done", done, 1'b0);
        chk("t2_cpurst", cpu_reset, 1'b1);
        chk("t2_own", bus_own, 1'b0);

        // T3: address wrap 0xFFFF -> 0x0000; CHK = 0x100 - 0x33 = 0xCD.
        frame = '{8'hFF, 8'hFF, 8'h02, 8'h00, 8'h11, 8'h22, 8'hCD};
        pulse_start();
        chk("t3_err_clr", error, 2'b00);
        send_frame(0);
        wait_end("t3_tmo");
        chk("t3_done", done, 1'b1);
        chk("t3_err", error, 2'b00);
        chk("t3_mffff", mem[16'hFFFF], 8'h11);
        chk("t3_m0000", mem[16'h0000], 8'h22);

        // T4: memory returns 0x00 at 0x0201 during verify.
        force_bad = 1'b1;
        frame = '{8'h00, 8'h02, 8'h03, 8'h00, 8'hA9, 8'h01, 8'h85, 8'hCC};
        pulse_start();
        send_frame(0);
        wait_end("t4_tmo");
        chk("t4_err", error, 2'b10);
        chk("t4_done", done, 1'b0);
        chk("t4_cpurst", cpu_reset, 1'b1);
        force_bad = 1'b0;

        // T5: empty payload, no write cycles at all.
        wr_base = wr_cnt;
        frame = '{8'h00, 8'h03, 8'h00, 8'h00, 8'hFD};
        pulse_start();
        send_frame(0);
        wait_end("t5_tmo");
        chk("t5_done", done, 1'b1);
        chk("t5_err", error, 2'b00);
        chk("t5_writes", wr_cnt - wr_base, 0);

        // T6: gaps, ignored mid-session start, async reset mid-RECV, reload.
        pulse_start();
        send(8'h00, 2); send(8'h04, 1); send(8'h02, 3); send(8'h00, 0);
        send(8'hAA, 2);
        pulse_start();
        chk("t6_ign_rdy", in_ready, 1'b1);
        chk("t6_ign_own", bus_own, 1'b1);
        chk("t6_ign_done", done, 1'b0);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("t6_arst");
        chk("t6_partial", mem[16'h0400], 8'hAA);
        @(negedge ph1);
        reset = 1'b0;
        @(negedge ph1);
        chk("t6_idle_own", bus_own, 1'b0);
        // 0x04 + 0x02 + 0x5A + 0xA5 = 0x105 -> CHK = 0xFB.
        frame = '{8'h00, 8'h04, 8'h02, 8'h00, 8'h5A, 8'hA5, 8'hFB};
        pulse_start();
        send_frame(3);
        wait_end("t6_tmo");
        chk("t6_done", done, 1'b1);
        chk("t6_err", error, 2'b00);
        chk("t6_m400", mem[16'h0400], 8'h5A);
        chk("t6_m401", mem[16'h0401], 8'hA5);
        chk("t6_cpurst", cpu_reset, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
